// File: rtl/eth_pkg.sv
`default_nettype none
// eth_pkg: shared constants and parser state encoding for the Ethernet RX header path.
// Rev 1.0
package eth_pkg;

  localparam int          ETH_HDR_BYTES     = 14;
  localparam int          ETH_MAC_BYTES     = 6;
  localparam logic [47:0] ETH_BROADCAST_MAC = 48'hffff_ffff_ffff;
  // Payload skid word: {tdata[7:0], tlast, tuser}
  localparam int          ETH_SKID_W        = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DROP    = 2'd3
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/eth_axis_rx_hdr_if.sv
`default_nettype none
// eth_axis_rx_hdr_if: frame input stream, header word and payload stream of the RX header parser.
// Rev 1.0
interface eth_axis_rx_hdr_if;

  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic        s_axis_tuser;

  logic        m_eth_hdr_valid;
  logic        m_eth_hdr_ready;
  logic [47:0] m_eth_dest_mac;
  logic [47:0] m_eth_src_mac;
  logic [15:0] m_eth_type;

  logic [7:0]  m_eth_payload_tdata;
  logic        m_eth_payload_tvalid;
  logic        m_eth_payload_tready;
  logic        m_eth_payload_tlast;
  logic        m_eth_payload_tuser;

  // slave: the parser itself; master: the surrounding MAC FIFO and consumers
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    output s_axis_tready,
    output m_eth_hdr_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type,
    input  m_eth_hdr_ready,
    output m_eth_payload_tdata, m_eth_payload_tvalid, m_eth_payload_tlast, m_eth_payload_tuser,
    input  m_eth_payload_tready
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    input  s_axis_tready,
    input  m_eth_hdr_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type,
    output m_eth_hdr_ready,
    input  m_eth_payload_tdata, m_eth_payload_tvalid, m_eth_payload_tlast, m_eth_payload_tuser,
    output m_eth_payload_tready
  );

endinterface
`default_nettype wire

// File: rtl/eth_axis_skid.sv
`default_nettype none
// eth_axis_skid: 1-deep registered skid buffer; full throughput with a registered upstream ready.
// Rev 1.0
module eth_axis_skid
  import eth_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ETH_SKID_W-1:0] s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [ETH_SKID_W-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i
);

  logic [ETH_SKID_W-1:0] out_q;
  logic [ETH_SKID_W-1:0] skid_q;
  logic                  out_valid_q;
  logic                  skid_valid_q;
  logic                  ready_q;
  logic                  w_in_fire;
  logic                  w_out_free;

  assign w_in_fire  = s_valid_i && ready_q;
  assign w_out_free = m_ready_i || !out_valid_q;

  // The skid register only fills when the output is blocked; ready drops for exactly that case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else if (w_out_free) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
        ready_q      <= 1'b1;
      end else begin
        out_valid_q <= w_in_fire;
        if (w_in_fire) out_q <= s_data_i;
      end
    end else if (w_in_fire) begin
      skid_q       <= s_data_i;
      skid_valid_q <= 1'b1;
      ready_q      <= 1'b0;
    end
  end

  assign s_ready_o = ready_q;
  assign m_data_o  = out_q;
  assign m_valid_o = out_valid_q;

endmodule
`default_nettype wire

// File: rtl/eth_axis_rx_hdr.sv
`default_nettype none
// eth_axis_rx_hdr: strips the 14-byte Ethernet header into one word and forwards the payload stream.
// Rev 1.0 -- optional destination-MAC filter enabled by `ETH_RX_MAC_FILTER_EN.
module eth_axis_rx_hdr
  import eth_pkg::*;
#(
  parameter bit ACCEPT_BROADCAST = 1'b1,
  parameter bit ACCEPT_MULTICAST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  eth_axis_rx_hdr_if.slave  bus,
  input  logic [47:0]       local_mac,
  output logic              busy,
  output logic              error_header_early_term,
  output logic              frame_dropped
);

  localparam logic [3:0] HDR_LAST_IDX = 4'(ETH_HDR_BYTES - 1);
  localparam logic [3:0] MAC_LAST_IDX = 4'(ETH_MAC_BYTES - 1);

  rx_state_e              state_q;
  logic [3:0]             cnt_q;
  logic [103:0]           shift_q;
  logic                   hdr_valid_q;
  logic [47:0]            dest_q;
  logic [47:0]            src_q;
  logic [15:0]            type_q;
  logic                   err_q;
  logic                   drop_q;

  logic                   w_s_ready;
  logic                   w_accept;
  logic                   w_skid_ready;
  logic                   w_match;
  logic [111:0]           w_hdr;
  logic [ETH_SKID_W-1:0]  w_skid_out;
  logic                   w_unused_cfg;

  assign w_unused_cfg = ^{local_mac, ETH_BROADCAST_MAC, ACCEPT_BROADCAST, ACCEPT_MULTICAST};

`ifdef ETH_RX_MAC_FILTER_EN
  logic [47:0] w_dest_early;
  assign w_dest_early = {shift_q[39:0], bus.s_axis_tdata};
  assign w_match = (w_dest_early == local_mac)
                || (ACCEPT_BROADCAST && (w_dest_early == ETH_BROADCAST_MAC))
                || (ACCEPT_MULTICAST && w_dest_early[40]);
`else
  assign w_match = 1'b1;
`endif

  // Header capture stalls while the previous word is still waiting for its consumer.
  always_comb begin
    case (state_q)
      ST_PAYLOAD: w_s_ready = w_skid_ready;
      ST_DROP:    w_s_ready = 1'b1;
      default:    w_s_ready = !(hdr_valid_q && !bus.m_eth_hdr_ready);
    endcase
  end

  assign w_accept = bus.s_axis_tvalid && w_s_ready;
  assign w_hdr    = {shift_q, bus.s_axis_tdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      shift_q     <= '0;
      hdr_valid_q <= 1'b0;
      dest_q      <= '0;
      src_q       <= '0;
      type_q      <= '0;
      err_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      err_q  <= 1'b0;
      drop_q <= 1'b0;
      if (bus.m_eth_hdr_ready) hdr_valid_q <= 1'b0;
      if (w_accept) begin
        case (state_q)
          ST_IDLE, ST_HEADER: begin
            shift_q <= {shift_q[95:0], bus.s_axis_tdata};
            if (cnt_q == HDR_LAST_IDX) begin
              // A retiring word and a new one in the same cycle keep valid high.
              hdr_valid_q <= 1'b1;
              dest_q      <= w_hdr[111:64];
              src_q       <= w_hdr[63:16];
              type_q      <= w_hdr[15:0];
              cnt_q       <= bus.s_axis_tlast ? 4'd0 : 4'(ETH_HDR_BYTES);
              state_q     <= bus.s_axis_tlast ? ST_IDLE : ST_PAYLOAD;
            end else if ((cnt_q == MAC_LAST_IDX) && !w_match) begin
              drop_q  <= bus.s_axis_tlast;
              cnt_q   <= bus.s_axis_tlast ? 4'd0 : cnt_q + 4'd1;
              state_q <= bus.s_axis_tlast ? ST_IDLE : ST_DROP;
            end else if (bus.s_axis_tlast) begin
              err_q   <= 1'b1;
              cnt_q   <= 4'd0;
              state_q <= ST_IDLE;
            end else begin
              cnt_q   <= cnt_q + 4'd1;
              state_q <= ST_HEADER;
            end
          end
          ST_PAYLOAD: begin
            if (bus.s_axis_tlast) begin
              cnt_q   <= 4'd0;
              state_q <= ST_IDLE;
            end
          end
          ST_DROP: begin
            if (bus.s_axis_tlast) begin
              drop_q  <= 1'b1;
              cnt_q   <= 4'd0;
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  eth_axis_skid u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  ({bus.s_axis_tdata, bus.s_axis_tlast, bus.s_axis_tlast & bus.s_axis_tuser}),
    .s_valid_i ((state_q == ST_PAYLOAD) && bus.s_axis_tvalid),
    .s_ready_o (w_skid_ready),
    .m_data_o  (w_skid_out),
    .m_valid_o (bus.m_eth_payload_tvalid),
    .m_ready_i (bus.m_eth_payload_tready)
  );

  assign bus.s_axis_tready        = w_s_ready;
  assign bus.m_eth_hdr_valid      = hdr_valid_q;
  assign bus.m_eth_dest_mac       = dest_q;
  assign bus.m_eth_src_mac        = src_q;
  assign bus.m_eth_type           = type_q;
  assign bus.m_eth_payload_tdata  = w_skid_out[9:2];
  assign bus.m_eth_payload_tlast  = w_skid_out[1];
  assign bus.m_eth_payload_tuser  = w_skid_out[0];
  assign busy                     = (state_q != ST_IDLE);
  assign error_header_early_term  = err_q;
  assign frame_dropped            = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_axis_rx_hdr.sv
`default_nettype none
// tb_eth_axis_rx_hdr: randomized bench for the RX header parser against a frame-level reference model.
// Rev 1.0
module tb_eth_axis_rx_hdr;

  localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] local_mac;
  logic        busy, err_p, drop_p;

  eth_axis_rx_hdr_if bus();

  eth_axis_rx_hdr u_dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .bus                     (bus),
    .local_mac               (local_mac),
    .busy                    (busy),
    .error_header_early_term (err_p),
    .frame_dropped           (drop_p)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, cyc = 0;
  logic [111:0] exp_hdr[$];
  logic [9:0]   exp_pay[$];
  int exp_err = 0, exp_drop = 0, err_seen = 0, drop_seen = 0, hdr_seen = 0;
  int beat_cnt = 0, beat_first = 0, beat_last = 0;
  logic [111:0] last_hdr;
  int pay_mode = 1, hdr_mode = 1;
  logic [7:0] fr[$], fr1[$], fr2[$];
  bit t3_done;
  logic p_pv = 0, p_pr = 0, p_hv = 0, p_hr = 0, p_rst = 0;
  logic [9:0]   p_pd;
  logic [111:0] p_h;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a frame's header is its first 14 bytes, the rest is payload.
  function automatic logic [111:0] hdr_of(input logic [7:0] f[$]);
    logic [111:0] h = '0;
    for (int i = 0; i < 14; i++) h = {h[103:0], f[i]};
    return h;
  endfunction

  function automatic void model_frame(input logic [7:0] f[$], input logic user);
    int n = f.size();
    logic [47:0] d = '0;
    bit drop = 1'b0;
    for (int i = 0; i < 6 && i < n; i++) d = {d[39:0], f[i]};
`ifdef ETH_RX_MAC_FILTER_EN
    if (n >= 6 && !(d == LOCAL_MAC || d == 48'hffff_ffff_ffff)) drop = 1'b1;
`endif
    if (drop) exp_drop++;
    else if (n < 14) exp_err++;
    else begin
      exp_hdr.push_back(hdr_of(f));
      for (int i = 14; i < n; i++)
        exp_pay.push_back({f[i], (i == n - 1), (i == n - 1) ? user : 1'b0});
    end
  endfunction

  function automatic void mk_frame(input int len, input logic [47:0] dest, input logic [15:0] et);
    fr.delete();
    for (int i = 0; i < len; i++) begin
      if (i < 6)       fr.push_back(dest[47 - 8*i -: 8]);
      else if (i < 12) fr.push_back(8'($urandom));
      else if (i < 14) fr.push_back(et[15 - 8*(i-12) -: 8]);
      else             fr.push_back(8'($urandom));
    end
  endfunction

  task automatic send_frame(input logic [7:0] f[$], input logic user, input bit gaps, input bit mark_last);
    for (int i = 0; i < f.size(); i++) begin
      bit acc = 1'b0;
      int t = 0;
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.s_axis_tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      bus.s_axis_tdata  = f[i];
      bus.s_axis_tlast  = mark_last && (i == f.size() - 1);
      bus.s_axis_tuser  = (mark_last && (i == f.size() - 1)) ? user : 1'b0;
      bus.s_axis_tvalid = 1'b1;
      while (!acc && t < 3000) begin
        @(negedge clk);
        acc = bus.s_axis_tready;
        t++;
        @(posedge clk);
        #1;
      end
      if (!acc) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tuser  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((exp_hdr.size() != 0 || exp_pay.size() != 0) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_drain"}, exp_hdr.size() + exp_pay.size(), 0);
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    bus.m_eth_payload_tready = (pay_mode == 2) ? 1'($urandom_range(0, 1)) : (pay_mode == 1);
    bus.m_eth_hdr_ready      = (hdr_mode == 2) ? 1'($urandom_range(0, 1)) : (hdr_mode == 1);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.m_eth_hdr_valid && bus.m_eth_hdr_ready) begin
        hdr_seen++;
        last_hdr = {bus.m_eth_dest_mac, bus.m_eth_src_mac, bus.m_eth_type};
        if (exp_hdr.size() == 0) chk("hdr_unexpected", 1, 0);
        else chk("hdr_word", last_hdr, exp_hdr.pop_front());
      end
      if (bus.m_eth_payload_tvalid && bus.m_eth_payload_tready) begin
        if (beat_cnt == 0) beat_first = cyc;
        beat_last = cyc;
        beat_cnt++;
        if (exp_pay.size() == 0) chk("pay_unexpected", 1, 0);
        else chk("pay_beat", {bus.m_eth_payload_tdata, bus.m_eth_payload_tlast, bus.m_eth_payload_tuser},
                 exp_pay.pop_front());
      end
      if (err_p)  err_seen++;
      if (drop_p) drop_seen++;
      if (p_rst && p_pv && !p_pr)
        chk("pay_hold", {bus.m_eth_payload_tvalid, bus.m_eth_payload_tdata, bus.m_eth_payload_tlast,
                         bus.m_eth_payload_tuser}, {1'b1, p_pd});
      if (p_rst && p_hv && !p_hr)
        chk("hdr_hold", {bus.m_eth_hdr_valid, bus.m_eth_dest_mac, bus.m_eth_src_mac, bus.m_eth_type},
            {1'b1, p_h});
    end
    p_rst = rst_n;
    p_pv  = bus.m_eth_payload_tvalid;
    p_pr  = bus.m_eth_payload_tready;
    p_pd  = {bus.m_eth_payload_tdata, bus.m_eth_payload_tlast, bus.m_eth_payload_tuser};
    p_hv  = bus.m_eth_hdr_valid;
    p_hr  = bus.m_eth_hdr_ready;
    p_h   = {bus.m_eth_dest_mac, bus.m_eth_src_mac, bus.m_eth_type};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int e0, h0, b0, d0;
    logic [63:0]  r64;
    logic [47:0]  dst;
    rst_n             = 1'b0;
    local_mac         = LOCAL_MAC;
    bus.s_axis_tdata  = 8'h00;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tuser  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hdr_valid", bus.m_eth_hdr_valid, 0);
    chk("rst_pay_valid", bus.m_eth_payload_tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_p, 0);
    chk("rst_drop", drop_p, 0);
    chk("rst_hdr_fields", {bus.m_eth_dest_mac, bus.m_eth_src_mac, bus.m_eth_type}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 60-byte IPv4 frame, everything ready: 46 back-to-back payload beats
    beat_cnt = 0;
    mk_frame(60, LOCAL_MAC, 16'h0800);
    model_frame(fr, 1'b0);
    send_frame(fr, 1'b0, 1'b0, 1'b1);
    drain("t1");
    chk("t1_beats", beat_cnt, 46);
    chk("t1_span", beat_last - beat_first, 45);
    chk("t1_dest", last_hdr[111:64], 48'h020000000001);
    chk("t1_type", last_hdr[15:0], 16'h0800);

    // 10-byte runt frame
    e0 = err_seen; h0 = hdr_seen; b0 = beat_cnt;
    mk_frame(10, LOCAL_MAC, 16'h0800);
    model_frame(fr, 1'b0);
    send_frame(fr, 1'b0, 1'b0, 1'b1);
    drain("t2");
    chk("t2_err_pulse", err_seen - e0, 1);
    chk("t2_no_hdr", hdr_seen - h0, 0);
    chk("t2_no_pay", beat_cnt - b0, 0);
    chk("t2_busy", busy, 0);

    // back-to-back frames with the header consumer stalled
    hdr_mode = 0;
    mk_frame(64, LOCAL_MAC, 16'h0806); fr1 = fr;
    mk_frame(64, LOCAL_MAC, 16'h86dd); fr2 = fr;
    model_frame(fr1, 1'b0);
    model_frame(fr2, 1'b1);
    t3_done = 1'b0;
    fork
      begin
        send_frame(fr1, 1'b0, 1'b0, 1'b1);
        send_frame(fr2, 1'b1, 1'b0, 1'b1);
        t3_done = 1'b1;
      end
    join_none
    repeat (120) @(posedge clk);
    @(negedge clk);
    chk("t3_stall_tready", bus.s_axis_tready, 0);
    chk("t3_stall_tvalid", bus.s_axis_tvalid, 1);
    chk("t3_stall_busy", busy, 0);
    chk("t3_hdr_pending", bus.m_eth_hdr_valid, 1);
    @(posedge clk);
    #1;
    hdr_mode = 1;
    for (int t = 0; t < 3000 && !t3_done; t++) @(posedge clk);
    chk("t3_done", t3_done, 1);
    drain("t3");

    // randomized frames, backpressure on both outputs
    pay_mode = 2; hdr_mode = 2;
    for (int k = 0; k < 25; k++) begin
      int sel, len;
      logic u;
      sel = $urandom_range(0, 9);
      len = (sel == 0) ? $urandom_range(1, 13) : (sel == 1) ? 14 : $urandom_range(15, 80);
      r64 = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       dst = 48'hffff_ffff_ffff;
        1:       dst = r64[47:0];
        default: dst = LOCAL_MAC;
      endcase
      u = 1'($urandom_range(0, 1));
      mk_frame(len, dst, 16'($urandom));
      model_frame(fr, u);
      send_frame(fr, u, 1'b1, 1'b1);
    end
    drain("t4");
    pay_mode = 1; hdr_mode = 1;

`ifdef ETH_RX_MAC_FILTER_EN
    d0 = drop_seen; h0 = hdr_seen; b0 = beat_cnt;
    mk_frame(30, 48'h02_00_00_00_00_02, 16'h0800);
    model_frame(fr, 1'b0);
    send_frame(fr, 1'b0, 1'b0, 1'b1);
    drain("t5a");
    chk("t5_drop_pulse", drop_seen - d0, 1);
    chk("t5_drop_no_hdr", hdr_seen - h0, 0);
    chk("t5_drop_no_pay", beat_cnt - b0, 0);
    h0 = hdr_seen;
    mk_frame(30, 48'hffff_ffff_ffff, 16'h0806);
    model_frame(fr, 1'b0);
    send_frame(fr, 1'b0, 1'b0, 1'b1);
    drain("t5b");
    chk("t5_bcast_hdr", hdr_seen - h0, 1);
`else
    d0 = 0;
`endif

    // reset in the middle of the payload
    pay_mode = 0;
    mk_frame(60, LOCAL_MAC, 16'h0800);
    fr1 = fr[0:15];
    exp_hdr.push_back(hdr_of(fr));
    send_frame(fr1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t6_pre_pay_valid", bus.m_eth_payload_tvalid, 1);
    chk("t6_pre_hdr_taken", exp_hdr.size(), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_pay_valid", bus.m_eth_payload_tvalid, 0);
    chk("t6_rst_hdr_valid", bus.m_eth_hdr_valid, 0);
    chk("t6_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pay_mode = 1;
    @(posedge clk);
    #1;
    mk_frame(40, LOCAL_MAC, 16'h0800);
    model_frame(fr, 1'b1);
    send_frame(fr, 1'b1, 1'b0, 1'b1);
    drain("t6");

    chk("err_total", err_seen, exp_err);
    chk("drop_total", drop_seen, exp_drop);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
